// File: rtl/mux_n_1_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_n_1_rr_reg
//
// N-input, WIDTH-bit selector feeding a single registered output stage.
// Producers present data with valid/ready; one channel is granted per cycle
// either by a host-driven index (mode=0) or by round-robin arbitration among
// the valid channels (mode=1). The output is a one-entry register that can be
// drained and reloaded in the same cycle, so a busy stream moves one word per
// clock with no bubbles.
//
// Parameters
//   WIDTH : data width per channel
//   N     : number of input channels (2..16)
//   SELW  : index width, ceil(log2(N))
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   mode      in   0 = fixed select, 1 = round-robin
//   sel       in   channel index used in fixed-select mode
//   in_data   in   packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid  in   per-channel valid
//   in_ready  out  per-channel ready (combinational, at most one bit set)
//   out_data  out  registered selected data
//   out_src   out  registered index of the channel that produced out_data
//   out_valid out  registered output valid
//   out_ready in   consumer ready
// -----------------------------------------------------------------------------
module mux_n_1_rr_reg #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Registered state
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    // Arbitration
    logic             grant;
    logic [SELW-1:0]  grant_idx;
    logic [SELW:0]    cand;       // one extra bit so rr_ptr+offset never overflows before the wrap
    logic             can_load;
    logic             load;

    logic [WIDTH-1:0] ch_data [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Gated by rst_n so no producer sees ready while reset is held.
    assign can_load = rst_n && (!out_valid_q || out_ready);
    assign load     = can_load && grant;

    // Grant selection. In round-robin mode the scan runs from the farthest
    // offset down to offset 0, so the last hit (closest to rr_ptr) wins.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!mode) begin
            if (int'(sel) < N) begin
                grant     = in_valid[sel];
                grant_idx = sel;
            end
        end else begin
            for (int off = N - 1; off >= 0; off--) begin
                cand = {1'b0, rr_ptr_q} + (SELW+1)'(off);
                // Explicit wrap at N so non-power-of-two N never indexes past N-1.
                if (cand >= (SELW+1)'(N)) begin
                    cand = cand - (SELW+1)'(N);
                end
                if (in_valid[cand[SELW-1:0]]) begin
                    grant     = 1'b1;
                    grant_idx = cand[SELW-1:0];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = load && (grant_idx == SELW'(gi));
        end
    endgenerate

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_data_d  = ch_data[grant_idx];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                if (grant_idx == SELW'(N - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx + SELW'(1);
                end
            end
        end else if (out_valid_q && out_ready) begin
            // Drained with nothing to replace it: data/src keep last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_1_rr_reg.sv
// -----------------------------------------------------------------------------
// Testbench for mux_n_1_rr_reg (N=4, WIDTH=5).
// A behavioural model tracks the expected output register and round-robin
// position; a negedge process compares every DUT output against it each cycle.
// Directed scenarios add literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_mux_n_1_rr_reg;

    localparam int WIDTH = 5;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_src;
    logic                 out_valid;
    logic                 out_ready;

    int total = 0;
    int bad   = 0;

    mux_n_1_rr_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid, m_data, m_src, m_ptr;

    // Channel the rules say is granted this cycle, or -1.
    function automatic int model_grant();
        int k;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int off = 0; off < N; off++) begin
            k = (m_ptr + off) % N;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        int g;
        g = model_grant();
        if (rst_n !== 1'b1) return 0;
        if (m_valid == 1 && out_ready == 1'b0) return 0;
        if (g < 0) return 0;
        return 1 << g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        end else begin
            g = model_grant();
            if (model_ready() != 0) begin
                m_data  = int'(in_data[g*WIDTH +: WIDTH]);
                m_src   = g;
                m_valid = 1;
                if (mode) m_ptr = (g + 1) % N;
            end else if (m_valid == 1 && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Single compare process: every cycle, mid-period.
    always @(negedge clk) begin
        chk("cyc_out_valid", int'(out_valid), m_valid);
        chk("cyc_out_data",  int'(out_data),  m_data);
        chk("cyc_out_src",   int'(out_src),   m_src);
        chk("cyc_in_ready",  int'(in_ready),  model_ready());
    end

    function automatic logic [N*WIDTH-1:0] pack4(input int d0, d1, d2, d3);
        logic [N*WIDTH-1:0] v;
        v = '0;
        v[0*WIDTH +: WIDTH] = WIDTH'(d0);
        v[1*WIDTH +: WIDTH] = WIDTH'(d1);
        v[2*WIDTH +: WIDTH] = WIDTH'(d2);
        v[3*WIDTH +: WIDTH] = WIDTH'(d3);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset / idle ----
        rst_n     = 1'b0;
        mode      = 1'($urandom);
        sel       = SELW'($urandom);
        in_data   = (N*WIDTH)'($urandom);
        in_valid  = N'($urandom);
        out_ready = 1'($urandom);
        tick(); tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_out_src",   int'(out_src),   0);
        chk("rst_in_ready",  int'(in_ready),  0);
        $display("txn reset held: in_ready=%b out_valid=%0d", in_ready, out_valid);
        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = '0;
        tick();
        chk("idle_out_valid", int'(out_valid), 0);

        // ---- fixed select ----
        mode = 1'b0; sel = 2; out_ready = 1'b1;
        in_data  = pack4(5'h01, 5'h02, 5'h15, 5'h0A);
        in_valid = 4'b1111;
        #1;
        chk("fix2_in_ready", int'(in_ready), 4'b0100);
        tick();
        chk("fix2_out_data",  int'(out_data),  5'h15);
        chk("fix2_out_src",   int'(out_src),   2);
        chk("fix2_out_valid", int'(out_valid), 1);
        $display("txn fixed sel=2 -> src=%0d data=%h", out_src, out_data);
        sel = 3;
        #1;
        chk("fix3_in_ready", int'(in_ready), 4'b1000);
        tick();
        chk("fix3_out_data", int'(out_data), 5'h0A);
        chk("fix3_out_src",  int'(out_src),  3);
        $display("txn fixed sel=3 -> src=%0d data=%h", out_src, out_data);

        // ---- round-robin fairness (pointer still 0) ----
        mode    = 1'b1;
        in_data = pack4(1, 2, 3, 4);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_src",   int'(out_src),   i % 4);
            chk("rr_data",  int'(out_data),  (i % 4) + 1);
            chk("rr_valid", int'(out_valid), 1);
            $display("txn rr %0d -> src=%0d data=%h", i, out_src, out_data);
        end

        // ---- skip / wrap: move pointer to 3 via ch2 ----
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0010;
        #1;
        chk("wrap_ready_ch1", int'(in_ready), 4'b0010);
        tick();
        chk("wrap_src_ch1", int'(out_src), 1);
        in_valid = 4'b1001;
        #1;
        chk("wrap_ready_ch3", int'(in_ready), 4'b1000);
        tick();
        chk("wrap_src_ch3", int'(out_src), 3);
        #1;
        chk("wrap_ready_ch0", int'(in_ready), 4'b0001);
        tick();
        chk("wrap_src_ch0", int'(out_src), 0);
        $display("txn wrap sequence ended at src=%0d", out_src);

        // ---- back-pressure (pointer now 1) ----
        in_data  = pack4(0, 5'h1F, 5'h07, 0);
        in_valid = 4'b0010;
        tick();
        chk("bp_load_data", int'(out_data), 5'h1F);
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data",  int'(out_data),  5'h1F);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_ready", int'(in_ready),  0);
        end
        in_valid  = 4'b0100;
        #1;
        chk("bp_stall_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(in_ready), 4'b0100);
        tick();
        chk("bp_reload_data", int'(out_data), 5'h07);
        $display("txn back-pressure released -> data=%h", out_data);

        // ---- async reset mid-stream ----
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        chk("ar_pre_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_drop", int'(out_valid), 0);
        chk("ar_in_ready",   int'(in_ready),  0);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = pack4(5'h11, 5'h12, 5'h13, 5'h14);
        out_ready = 1'b1;
        tick();
        chk("ar_first_src",  int'(out_src),  0);
        chk("ar_first_data", int'(out_data), 5'h11);
        $display("txn after async reset -> src=%0d data=%h", out_src, out_data);

        // ---- randomized phase ----
        for (int i = 0; i < 3000; i++) begin
            mode      = 1'($urandom);
            sel       = SELW'($urandom);
            in_data   = (N*WIDTH)'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (i % 250 == 0)
                $display("txn rand %0d: out_valid=%0d src=%0d data=%h", i, out_valid, out_src, out_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
